// File: rtl/rw_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rw_mem_arbiter
//
// Two-port arbiter and sequencer for the 96x8 synchronous read/write data
// memory (addresses 128..223). Port 0 is the CPU, port 1 the loader/DMA.
// One request is accepted at a time, with round-robin fairness on a tie.
// The block drives the single memory port, captures read data one cycle
// after the read edge, and returns a one-cycle ack to the winning port.
//
// Optional feature (compile-time macro):
//   RW_ARB_RANGE_CHECK_EN - when defined, an accepted address outside
//     ADDR_LO..ADDR_HI is not forwarded to memory. The transaction completes
//     one cycle after acceptance with err set (and rdata cleared for a read).
//     When undefined, every address is forwarded and err0/err1 are always 0.
//
// Parameters:
//   ADDR_LO       lowest valid RW address  (default 128)
//   ADDR_HI       highest valid RW address (default 223)
//
// Ports:
//   clock         system clock, rising-edge active
//   reset         asynchronous, active-high reset
//   req0/req1     request, held high until the matching ack
//   we0/we1       1 = write, 0 = read; valid with req
//   addr0/addr1   byte address
//   wdata0/wdata1 write data
//   ack0/ack1     one-cycle completion pulse
//   rdata0/rdata1 read data; valid during ack, held until the next read
//   err0/err1     address-range error, valid during ack
//   busy          high whenever the sequencer is not idle
//   mem_address   memory address
//   mem_data_in   memory write data
//   mem_write     memory write strobe
//   mem_data_out  memory read data, valid the cycle after a read edge
// -----------------------------------------------------------------------------
module rw_mem_arbiter #(
    parameter logic [7:0] ADDR_LO = 8'd128,
    parameter logic [7:0] ADDR_HI = 8'd223
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err0,
    output logic       err1,
    output logic       busy,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_in,
    output logic       mem_write,
    input  logic [7:0] mem_data_out
);

`ifdef RW_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       gnt;        // port owning the in-flight transaction
    logic       last_gnt;   // port granted most recently (round-robin pointer)
    logic       we_q;       // latched write flag of the in-flight transaction
    logic       err_q;      // in-flight transaction was rejected for its address

    logic       any_req;
    logic       win;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic       out_of_range;
    logic       range_err;

    // -------------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on a tie the port that was
    // not granted last time wins.
    // -------------------------------------------------------------------------
    always_comb begin
        any_req      = req0 | req1;
        win          = (req0 && req1) ? ~last_gnt : req1;
        sel_we       = win ? we1    : we0;
        sel_addr     = win ? addr1  : addr0;
        sel_wdata    = win ? wdata1 : wdata0;
        out_of_range = (sel_addr < ADDR_LO) || (sel_addr > ADDR_HI);
        range_err    = RANGE_CHECK && out_of_range;
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    // A rejected address completes without touching memory.
                    state_next = range_err ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = we_q ? S_DONE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Acceptance latch, round-robin pointer and read-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt         <= 1'b0;
            last_gnt    <= 1'b1;  // port 0 wins the first tie
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_address <= 8'h00;
            mem_data_in <= 8'h00;
            rdata0      <= 8'h00;
            rdata1      <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt      <= win;
                        last_gnt <= win;
                        we_q     <= sel_we;
                        err_q    <= range_err;
                        if (!range_err) begin
                            mem_address <= sel_addr;
                            mem_data_in <= sel_wdata;
                        end else if (!sel_we) begin
                            // Rejected read returns zero on the winning port.
                            if (win) begin
                                rdata1 <= 8'h00;
                            end else begin
                                rdata0 <= 8'h00;
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Memory output is valid in this cycle; only the granted
                    // port's holding register is updated.
                    if (gnt) begin
                        rdata1 <= mem_data_out;
                    end else begin
                        rdata0 <= mem_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from the state, so they follow reset asynchronously.
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state != S_IDLE);
        mem_write = (state == S_ISSUE) && we_q;
        ack0      = (state == S_DONE) && !gnt;
        ack1      = (state == S_DONE) &&  gnt;
        err0      = ack0 && err_q;
        err1      = ack1 && err_q;
    end

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rw_mem_arbiter
//
// Directed bench for rw_mem_arbiter. A behavioural 256x8 synchronous memory
// (write and registered read on the same edge) sits on the memory port.
// Inputs are driven and outputs sampled on the falling clock edge.
// Works with or without RW_ARB_RANGE_CHECK_EN defined.
// -----------------------------------------------------------------------------
module tb_rw_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1, err0, err1, busy, mem_write;
    logic [7:0] rdata0, rdata1, mem_address, mem_data_in;
    logic [7:0] mem_data_out = 8'h00;

    logic [7:0] mem [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    rw_mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .err0         (err0),
        .err1         (err1),
        .busy         (busy),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    // Synchronous memory: write and read both act at the rising edge, read
    // data appears the cycle after.
    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on a single port. Returns the ack latency in cycles
    // after acceptance (-1 if no ack within the budget), the number of
    // mem_write cycles seen, the last address written, rdata/err at ack, and
    // whether the other port acked.
    task automatic txn(input bit port, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, output int lat, output int wr_pulses,
                       output logic [7:0] wr_addr, output logic [7:0] rd,
                       output bit er, output bit other_ack);
        @(negedge clock);
        // NOTE: stimulus is applied with blocking assignments on the falling
        // edge so it is stable well before the next rising edge.
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        lat = -1; wr_pulses = 0; wr_addr = 8'h00; rd = 8'h00; er = 1'b0; other_ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (mem_write) begin
                wr_pulses++;
                wr_addr = mem_address;
            end
            if (port ? ack0 : ack1) other_ack = 1'b1;
            if (port ? ack1 : ack0) begin
                lat = k;
                rd  = port ? rdata1 : rdata0;
                er  = port ? err1 : err0;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, wp, n, dual, dbl, bad_rd, stray;
        int         order [4];
        int         exp_order [4];
        logic [7:0] wa, rd;
        bit         er, oa, prev0, prev1;

        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_busy",     busy,        1'b0);
        check("rst_ack0",     ack0,        1'b0);
        check("rst_ack1",     ack1,        1'b0);
        check("rst_err0",     err0,        1'b0);
        check("rst_err1",     err1,        1'b0);
        check("rst_rdata0",   rdata0,      8'h00);
        check("rst_rdata1",   rdata1,      8'h00);
        check("rst_mem_addr", mem_address, 8'h00);
        check("rst_mem_din",  mem_data_in, 8'h00);
        check("rst_mem_wr",   mem_write,   1'b0);

        // Port 0 writes 0x5A to 0x80
        txn(1'b0, 1'b1, 8'h80, 8'h5A, lat, wp, wa, rd, er, oa);
        check("w80_lat",    lat, 2);
        check("w80_pulses", wp,  1);
        check("w80_addr",   wa,  8'h80);
        check("w80_ack1",   oa,  1'b0);
        check("w80_err",    er,  1'b0);

        // Port 1 reads it back; port 0 rdata untouched
        txn(1'b1, 1'b0, 8'h80, 8'h00, lat, wp, wa, rd, er, oa);
        check("r80_lat",    lat,    3);
        check("r80_data",   rd,     8'h5A);
        check("r80_pulses", wp,     0);
        check("r80_rdata0", rdata0, 8'h00);
        check("r80_ack0",   oa,     1'b0);

        // Port 1 writes boundary 0xDF
        txn(1'b1, 1'b1, 8'hDF, 8'hC3, lat, wp, wa, rd, er, oa);
        check("wdf_lat",  lat, 2);
        check("wdf_addr", wa,  8'hDF);

        // Tie: both reads held; grant order must alternate starting at port 0
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h80;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hDF;
        n = 0; dual = 0; dbl = 0; bad_rd = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clock);
            if (ack0 && ack1) dual++;
            if (ack0 && prev0) dbl++;
            if (ack1 && prev1) dbl++;
            if (ack0 && !prev0) begin
                order[n] = 0;
                if (rdata0 !== 8'h5A) bad_rd++;
                n++;
            end else if (ack1 && !prev1) begin
                order[n] = 1;
                if (rdata1 !== 8'hC3) bad_rd++;
                n++;
            end
            prev0 = ack0;
            prev1 = ack1;
            if (n == 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("tie_count", n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("tie_order%0d", i), order[i], exp_order[i]);
        check("tie_dual_ack",   dual,   0);
        check("tie_long_ack",   dbl,    0);
        check("tie_read_data",  bad_rd, 0);

        // Reset in the RD_WAIT cycle of a port 1 read
        @(negedge clock);
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hDF;
        @(negedge clock);   // ISSUE
        @(negedge clock);   // RD_WAIT
        check("midrst_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_busy",   busy,      1'b0);
        check("midrst_ack0",   ack0,      1'b0);
        check("midrst_ack1",   ack1,      1'b0);
        check("midrst_mem_wr", mem_write, 1'b0);
        check("midrst_rdata1", rdata1,    8'h00);
        req1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clock);
            if (ack0 || ack1) stray++;
        end
        check("midrst_no_ack", stray, 0);
        txn(1'b1, 1'b0, 8'hDF, 8'h00, lat, wp, wa, rd, er, oa);
        check("postrst_lat",  lat, 3);
        check("postrst_data", rd,  8'hC3);

        // Out-of-range write to 0x10
        txn(1'b0, 1'b1, 8'h10, 8'h77, lat, wp, wa, rd, er, oa);
`ifdef RW_ARB_RANGE_CHECK_EN
        check("w10_lat",      lat,         1);
        check("w10_pulses",   wp,          0);
        check("w10_err",      er,          1'b1);
        check("w10_mem_addr", mem_address, 8'hDF);
`else
        check("w10_lat",      lat,         2);
        check("w10_pulses",   wp,          1);
        check("w10_addr",     wa,          8'h10);
        check("w10_err",      er,          1'b0);
`endif

        // Boundary round trips
        txn(1'b0, 1'b1, 8'h80, 8'h3C, lat, wp, wa, rd, er, oa);
        check("b80_w_lat", lat, 2);
        txn(1'b1, 1'b0, 8'h80, 8'h00, lat, wp, wa, rd, er, oa);
        check("b80_r_data", rd, 8'h3C);
        check("b80_r_err",  er, 1'b0);
        txn(1'b1, 1'b1, 8'hDF, 8'hE1, lat, wp, wa, rd, er, oa);
        check("bdf_w_lat", lat, 2);
        txn(1'b0, 1'b0, 8'hDF, 8'h00, lat, wp, wa, rd, er, oa);
        check("bdf_r_data",  rd,     8'hE1);
        check("bdf_r_err",   er,     1'b0);
        check("bdf_rdata1",  rdata1, 8'h3C);

        // Just outside the window
        txn(1'b1, 1'b0, 8'hE0, 8'h00, lat, wp, wa, rd, er, oa);
`ifdef RW_ARB_RANGE_CHECK_EN
        check("re0_lat",  lat, 1);
        check("re0_err",  er,  1'b1);
        check("re0_data", rd,  8'h00);
`else
        check("re0_lat",  lat, 3);
        check("re0_err",  er,  1'b0);
`endif
        txn(1'b0, 1'b1, 8'h7F, 8'h99, lat, wp, wa, rd, er, oa);
`ifdef RW_ARB_RANGE_CHECK_EN
        check("w7f_lat",    lat, 1);
        check("w7f_err",    er,  1'b1);
        check("w7f_pulses", wp,  0);
`else
        check("w7f_lat",    lat, 2);
        check("w7f_err",    er,  1'b0);
        check("w7f_addr",   wa,  8'h7F);
`endif

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
